// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO read-side burst arbiter: state encoding,
// gray-to-binary conversion and beat counter sizing. No logic, no latency.
package fifo_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam int GRAY_MAX_W = 32;

    // Works for any pointer up to GRAY_MAX_W bits when zero-extended:
    // the extra high zeros do not change the running XOR.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
        logic [GRAY_MAX_W-1:0] bin;
        bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

    function automatic int beat_cnt_w(input int burst_len);
        return $clog2(burst_len + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req at or after rr_ptr, wrapping.
// Zero latency; no handshake of its own, the caller decides when a pick is taken.
module rr_arbiter
    import fifo_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [IDX_W-1:0]   winner,
    output logic               any_req
);

    int               idx;
    logic [IDX_W-1:0] idx_w;

    always_comb begin
        winner  = rr_ptr;
        any_req = 1'b0;
        idx     = 0;
        idx_w   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx   = (int'(rr_ptr) + k) % NUM_REQ;
            idx_w = IDX_W'(idx);
            if (!any_req && req[idx_w]) begin
                any_req = 1'b1;
                winner  = idx_w;
            end
        end
    end

endmodule

// File: rtl/read_burst_arbiter.sv
// Shares the FIFO read port among NUM_REQ consumers in whole BURST_LEN-word bursts, round-robin.
// Grant one cycle after a qualifying request, data valid in the grant cycle; out_ready low stalls the pop.
module read_burst_arbiter
    import fifo_pkg::*;
#(
    parameter int ADDRESS_BITS = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int NUM_REQ      = 4,
    parameter int BURST_LEN    = 4
) (
    input  logic                    read_clk,
    input  logic                    read_rst,
    input  logic                    rempty,
    input  logic [ADDRESS_BITS:0]   read_ptr,
    input  logic [ADDRESS_BITS:0]   rq2_write_ptr,
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ-1:0]      out_ready,
    output logic                    read_inc,
    output logic [NUM_REQ-1:0]      gnt,
    output logic                    out_valid,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    out_last
);

    localparam int PW    = ADDRESS_BITS + 1;
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BW    = beat_cnt_w(BURST_LEN);

    if (BURST_LEN < 1 || BURST_LEN > (1 << ADDRESS_BITS)) begin : g_bad_burst_len
        $error("read_burst_arbiter: BURST_LEN must be in 1..2**ADDRESS_BITS");
    end
    if (NUM_REQ < 2) begin : g_bad_num_req
        $error("read_burst_arbiter: NUM_REQ must be at least 2");
    end
    if (PW > GRAY_MAX_W) begin : g_bad_ptr_w
        $error("read_burst_arbiter: pointer wider than gray2bin supports");
    end

    state_t             state_q,    state_d;
    logic [NUM_REQ-1:0] gnt_q,      gnt_d;
    logic [BW-1:0]      beat_cnt_q, beat_cnt_d;
    logic [IDX_W-1:0]   rr_ptr_q,   rr_ptr_d;
    logic [IDX_W-1:0]   winner_q,   winner_d;

    logic [PW-1:0]      wr_bin;
    logic [PW-1:0]      rd_bin;
    logic [PW-1:0]      occ;
    logic               burst_ready;
    logic [IDX_W-1:0]   arb_winner;
    logic               any_req;
    logic               hs;

    // The synchronised write pointer lags, so occ can only under-report.
    assign wr_bin      = PW'(gray2bin(GRAY_MAX_W'(rq2_write_ptr)));
    assign rd_bin      = PW'(gray2bin(GRAY_MAX_W'(read_ptr)));
    assign occ         = wr_bin - rd_bin;
    assign burst_ready = (occ >= PW'(BURST_LEN));

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req     (req),
        .rr_ptr  (rr_ptr_q),
        .winner  (arb_winner),
        .any_req (any_req)
    );

    always_ff @(posedge read_clk or negedge read_rst) begin
        if (!read_rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            beat_cnt_q <= '0;
            rr_ptr_q   <= '0;
            winner_q   <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            beat_cnt_q <= beat_cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            winner_q   <= winner_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        beat_cnt_d = beat_cnt_q;
        rr_ptr_d   = rr_ptr_q;
        winner_d   = winner_q;
        case (state_q)
            IDLE: begin
                if (any_req && burst_ready) begin
                    state_d    = BURST;
                    winner_d   = arb_winner;
                    gnt_d      = NUM_REQ'(1) << arb_winner;
                    beat_cnt_d = '0;
                end else begin
                    gnt_d = '0;
                end
            end
            BURST: begin
                if (hs) begin
                    if (out_last) begin
                        state_d    = IDLE;
                        gnt_d      = '0;
                        beat_cnt_d = '0;
                        rr_ptr_d   = (winner_q == IDX_W'(NUM_REQ - 1)) ? '0
                                                                       : winner_q + IDX_W'(1);
                    end else begin
                        beat_cnt_d = beat_cnt_q + BW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Only the granted consumer's ready is looked at; pops never happen outside a burst.
    always_comb begin
        out_valid = (state_q == BURST) && !rempty;
        hs        = out_valid && out_ready[winner_q];
        read_inc  = hs;
        out_last  = out_valid && (beat_cnt_q == BW'(BURST_LEN - 1));
    end

    assign gnt      = gnt_q;
    assign out_data = rdata;

endmodule

// File: tb/tb_read_burst_arbiter.sv
// Bench for read_burst_arbiter: models the FIFO around it and predicts grants, pops and data
// from the burst/round-robin rules using plain integers and a word queue.
module tb_read_burst_arbiter;

    localparam int AB    = 4;
    localparam int DW    = 8;
    localparam int N     = 4;
    localparam int BL    = 4;
    localparam int DEPTH = 16;
    localparam int PMOD  = 32;

    logic          read_clk = 1'b0;
    logic          read_rst;
    logic          rempty;
    logic [AB:0]   read_ptr;
    logic [AB:0]   rq2_write_ptr;
    logic [DW-1:0] rdata;
    logic [N-1:0]  req;
    logic [N-1:0]  out_ready;
    logic          read_inc;
    logic [N-1:0]  gnt;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_last;

    read_burst_arbiter #(
        .ADDRESS_BITS (AB),
        .DATA_WIDTH   (DW),
        .NUM_REQ      (N),
        .BURST_LEN    (BL)
    ) dut (
        .read_clk      (read_clk),
        .read_rst      (read_rst),
        .rempty        (rempty),
        .read_ptr      (read_ptr),
        .rq2_write_ptr (rq2_write_ptr),
        .rdata         (rdata),
        .req           (req),
        .out_ready     (out_ready),
        .read_inc      (read_inc),
        .gnt           (gnt),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_last      (out_last)
    );

    always #5 read_clk = ~read_clk;

    int            checks = 0;
    int            errors = 0;

    // FIFO environment: binary pointers mod 32, storage, and the expected word order.
    int            wptr = 0;
    int            rptr = 0;
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] sb [$];
    bit            push_en = 0;
    bit            ready_rand = 0;

    // Reference model: who owns the port, words delivered so far, where the rotation resumes.
    int            m_owner = -1;
    int            m_beats = 0;
    int            m_rr = 0;

    int            pops = 0;
    int            pops_total = 0;
    int            bursts_done = 0;
    logic [N-1:0]  prev_gnt = '0;
    int            gnt_log [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AB:0] bin2gray(input int b);
        logic [AB:0] v;
        v = (AB+1)'(b);
        return v ^ (v >> 1);
    endfunction

    function automatic int occ_f();
        return (wptr - rptr + PMOD) % PMOD;
    endfunction

    task automatic drive_fifo();
        read_ptr      = bin2gray(rptr);
        rq2_write_ptr = bin2gray(wptr);
        rdata         = mem[4'(rptr)];
        rempty        = (rptr == wptr);
    endtask

    task automatic push_word();
        logic [DW-1:0] w;
        w = DW'($urandom);
        mem[4'(wptr)] = w;
        sb.push_back(w);
        wptr = (wptr + 1) % PMOD;
    endtask

    task automatic cycle();
        int          occ;
        int          n_owner;
        int          n_beats;
        int          n_rr;
        int          gidx;
        logic        own_rdy;
        logic        e_valid;
        logic        e_hs;
        logic        e_last;
        logic [N-1:0] e_gnt;
        logic        dut_inc;

        if (ready_rand) out_ready = N'($urandom);
        drive_fifo();
        #1;
        occ     = occ_f();
        own_rdy = (m_owner >= 0) ? out_ready[m_owner[1:0]] : 1'b0;
        e_gnt   = (m_owner >= 0) ? N'(1 << m_owner) : '0;
        e_valid = (m_owner >= 0) && (occ != 0);
        e_hs    = e_valid && own_rdy;
        e_last  = e_valid && (m_beats == BL - 1);

        check("gnt",       32'(gnt),       32'(e_gnt));
        check("out_valid", 32'(out_valid), 32'(e_valid));
        check("read_inc",  32'(read_inc),  32'(e_hs));
        check("out_last",  32'(out_last),  32'(e_last));
        if (e_valid && sb.size() > 0) check("out_data", 32'(out_data), 32'(sb[0]));

        if (gnt != '0 && prev_gnt == '0) begin
            gidx = -1;
            for (int k = 0; k < N; k++) if (gnt[k]) gidx = k;
            gnt_log.push_back(gidx);
        end
        prev_gnt = gnt;
        if (read_inc) begin
            pops++;
            pops_total++;
            if (out_last) begin
                check("burst_words", 32'(pops), 32'(BL));
                pops = 0;
                bursts_done++;
            end
        end

        n_owner = m_owner;
        n_beats = m_beats;
        n_rr    = m_rr;
        if (m_owner < 0) begin
            if (req != '0 && occ >= BL) begin
                for (int k = N - 1; k >= 0; k--) begin
                    if (req[2'((m_rr + k) % N)]) n_owner = (m_rr + k) % N;
                end
                n_beats = 0;
            end
        end else if (e_hs) begin
            if (e_last) begin
                n_owner = -1;
                n_beats = 0;
                n_rr    = (m_owner + 1) % N;
            end else begin
                n_beats = m_beats + 1;
            end
        end

        dut_inc = read_inc;
        @(posedge read_clk);
        #1;
        if (dut_inc) begin
            rptr = (rptr + 1) % PMOD;
            if (sb.size() > 0) void'(sb.pop_front());
        end
        if (push_en && occ_f() < DEPTH) push_word();
        m_owner = n_owner;
        m_beats = n_beats;
        m_rr    = n_rr;
    endtask

    task automatic run_bursts(input int n, input int budget);
        int target;
        int used;
        target = bursts_done + n;
        used   = 0;
        while (bursts_done < target && used < budget) begin
            cycle();
            used++;
        end
        check("bursts_in_budget", 32'(bursts_done), 32'(target));
    endtask

    task automatic idle_cycles(input int n);
        req = '0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        int base;
        int used;

        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        read_rst  = 1'b0;
        req       = '0;
        out_ready = '1;
        drive_fifo();
        repeat (2) @(posedge read_clk);
        #1;

        // Reset state, even with every consumer requesting.
        req = '1;
        #1;
        check("rst_gnt",       32'(gnt),       32'(0));
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_read_inc",  32'(read_inc),  32'(0));
        check("rst_out_last",  32'(out_last),  32'(0));
        req = '0;
        @(posedge read_clk);
        #1;
        read_rst = 1'b1;

        // Occupancy gate: three words are not enough, the fourth starts the burst.
        req = 4'b0001;
        repeat (3) push_word();
        repeat (4) cycle();
        check("gate_no_gnt", 32'(gnt), 32'(0));
        push_word();
        run_bursts(1, 20);
        idle_cycles(2);

        // Asynchronous reset in the middle of a burst.
        repeat (8) push_word();
        req  = 4'b0001;
        used = 0;
        while (!(m_owner >= 0 && m_beats == 2) && used < 20) begin
            cycle();
            used++;
        end
        check("reach_beat2", 32'(m_beats), 32'(2));
        read_rst = 1'b0;
        #1;
        check("midrst_gnt",       32'(gnt),       32'(0));
        check("midrst_out_valid", 32'(out_valid), 32'(0));
        check("midrst_read_inc",  32'(read_inc),  32'(0));
        check("midrst_out_last",  32'(out_last),  32'(0));
        m_owner  = -1;
        m_beats  = 0;
        m_rr     = 0;
        pops     = 0;
        prev_gnt = '0;
        @(posedge read_clk);
        #1;
        read_rst = 1'b1;
        idle_cycles(2);

        // Round-robin with all consumers requesting and the FIFO kept topped up.
        gnt_log.delete();
        push_en = 1;
        req     = '1;
        run_bursts(5, 80);
        req = '0;
        check("rr_grants", 32'(gnt_log.size()), 32'(5));
        for (int i = 0; i < 5 && i < gnt_log.size(); i++) begin
            check("rr_order", 32'(gnt_log[i]), 32'(i % N));
        end
        idle_cycles(2);

        // Random back-pressure from the consumers.
        ready_rand = 1;
        req        = N'($urandom_range(1, 15));
        run_bursts(3, 300);
        ready_rand = 0;
        out_ready  = '1;
        idle_cycles(2);

        // Pointer wrap: restart the FIFO just below the 5-bit wrap point.
        push_en = 0;
        idle_cycles(1);
        rptr = 29;
        wptr = 29;
        sb.delete();
        push_en    = 1;
        ready_rand = 1;
        req        = N'($urandom_range(1, 15));
        run_bursts(4, 300);
        ready_rand = 0;
        out_ready  = '1;
        req        = '0;
        check("wrap_rptr", 32'(rptr), 32'((29 + 4 * BL) % PMOD));
        idle_cycles(2);

        // Consumer 2 drops its request after the first word; the burst still completes.
        gnt_log.delete();
        base = pops_total;
        req  = 4'b0100;
        used = 0;
        while (pops_total == base && used < 20) begin
            cycle();
            used++;
        end
        check("drop_first_pop", 32'(pops_total), 32'(base + 1));
        req = 4'b1011;
        run_bursts(2, 60);
        req = '0;
        check("drop_grants", 32'(gnt_log.size()), 32'(2));
        if (gnt_log.size() >= 2) begin
            check("drop_owner", 32'(gnt_log[0]), 32'(2));
            check("drop_next",  32'(gnt_log[1]), 32'(3));
        end
        idle_cycles(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
